// File: rtl/avalon_packet_arbiter_pkg.sv
// Shared types and helpers for the Avalon-ST packet arbiter.
//   arb_sm_t       : arbiter state (idle / locked to one source / emitting abort beat)
//   next_rr_index  : round-robin successor of an input index, wrapping at n
package arbiter_pack;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_LOCKED,
    ARB_ABORT
  } arb_sm_t;

  function automatic int next_rr_index(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Sanitised Avalon-ST stream bundle.
//   master : drives data/valid/sop/eop/empty, receives rdy
//   slave  : receives data/valid/sop/eop/empty, drives rdy
interface avalon_st_if #(
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2
);
  logic [DATA_W-1:0]  data;
  logic               valid;
  logic               sop;
  logic               eop;
  logic [EMPTY_W-1:0] empty;
  logic               rdy;

  modport master (output data, valid, sop, eop, empty, input rdy);
  modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority picker.
//   req   : request vector, one bit per input
//   ptr   : index holding highest priority this cycle
//   found : at least one request is set
//   idx   : first requesting index at or after ptr, wrapping modulo N_INPUTS
module rr_priority_picker #(
  parameter int N_INPUTS = 4,
  parameter int IDX_W    = $clog2(N_INPUTS)
) (
  input  logic [N_INPUTS-1:0] req,
  input  logic [IDX_W-1:0]    ptr,
  output logic                found,
  output logic [IDX_W-1:0]    idx
);

  // Rotate so that bit 0 of the low half is the input at ptr; the lowest set
  // bit then gives the distance from ptr to the winner.
  logic [2*N_INPUTS-1:0] rotated;

  assign rotated = {req, req} >> ptr;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Walk from the far end so the nearest request is the last one written.
    for (int k = N_INPUTS - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        found = 1'b1;
        idx   = IDX_W'((int'(ptr) + k) % N_INPUTS);
      end
    end
  end

endmodule

// File: rtl/avalon_packet_arbiter.sv
// Packet-level round-robin arbiter sharing one Avalon-ST output among
// N_INPUTS sources. A source that starts a packet owns the output until eop;
// an inactivity watchdog closes a stalled packet with an abort beat.
//   clk, rst      : clock, asynchronous active-low reset
//   in_msg[]      : requesting streams (rdy driven back by the arbiter)
//   out_msg       : shared output stream
//   grant         : one-hot owner while locked, 0 otherwise
//   busy          : locked to a source or emitting an abort beat
//   timeout_abort : pulse when the abort beat is accepted downstream
//   drop_beat     : pulse when an orphan non-sop beat is discarded in idle
module avalon_packet_arbiter
  import arbiter_pack::*;
#(
  parameter int N_INPUTS     = 4,
  parameter int IDLE_TIMEOUT = 64,
  parameter int DATA_W       = 32,
  parameter int EMPTY_W      = 2
) (
  input  logic                clk,
  input  logic                rst,
  avalon_st_if.slave          in_msg [N_INPUTS],
  avalon_st_if.master         out_msg,
  output logic [N_INPUTS-1:0] grant,
  output logic                busy,
  output logic                timeout_abort,
  output logic                drop_beat
);

  localparam int IDX_W = $clog2(N_INPUTS);
  localparam int CNT_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  // Interface arrays only accept constant indices, so flatten them once here
  // and do all dynamic selection on plain vectors.
  logic [N_INPUTS-1:0] in_valid, in_sop, in_eop, in_rdy;
  logic [DATA_W-1:0]   in_data  [N_INPUTS];
  logic [EMPTY_W-1:0]  in_empty [N_INPUTS];

  for (genvar g = 0; g < N_INPUTS; g++) begin : g_flat
    assign in_valid[g]  = in_msg[g].valid;
    assign in_sop[g]    = in_msg[g].sop;
    assign in_eop[g]    = in_msg[g].eop;
    assign in_data[g]   = in_msg[g].data;
    assign in_empty[g]  = in_msg[g].empty;
    assign in_msg[g].rdy = in_rdy[g];
  end

  arb_sm_t          state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0] grant_idx, grant_idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic             cand_found, disc_found;
  logic [IDX_W-1:0] cand_idx, disc_idx;
  logic             out_rdy;

  // Packet starts compete in round-robin order from rr_ptr.
  rr_priority_picker #(.N_INPUTS(N_INPUTS), .IDX_W(IDX_W)) u_cand_pick (
    .req   (in_valid & in_sop),
    .ptr   (rr_ptr),
    .found (cand_found),
    .idx   (cand_idx)
  );

  // Orphan beats are flushed lowest index first.
  rr_priority_picker #(.N_INPUTS(N_INPUTS), .IDX_W(IDX_W)) u_disc_pick (
    .req   (in_valid & ~in_sop),
    .ptr   ('0),
    .found (disc_found),
    .idx   (disc_idx)
  );

  assign out_rdy = out_msg.rdy;

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      grant_idx <= grant_idx_nxt;
      cnt       <= cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    grant_idx_nxt = grant_idx;
    cnt_nxt       = cnt;
    in_rdy        = '0;
    out_msg.valid = 1'b0;
    out_msg.sop   = 1'b0;
    out_msg.eop   = 1'b0;
    out_msg.data  = '0;
    out_msg.empty = '0;
    timeout_abort = 1'b0;
    drop_beat     = 1'b0;

    case (state)
      ARB_IDLE: begin
        if (cand_found) begin
          out_msg.valid    = 1'b1;
          out_msg.sop      = 1'b1;
          out_msg.eop      = in_eop[cand_idx];
          out_msg.data     = in_data[cand_idx];
          out_msg.empty    = in_eop[cand_idx] ? in_empty[cand_idx] : '0;
          in_rdy[cand_idx] = out_rdy;
          if (out_rdy) begin
            rr_ptr_nxt = IDX_W'(next_rr_index(int'(cand_idx), N_INPUTS));
            if (!in_eop[cand_idx]) begin
              state_nxt     = ARB_LOCKED;
              grant_idx_nxt = cand_idx;
              cnt_nxt       = '0;
            end
          end
        end else if (disc_found) begin
          in_rdy[disc_idx] = 1'b1;
          drop_beat        = 1'b1;
        end
      end

      ARB_LOCKED: begin
        out_msg.valid     = in_valid[grant_idx];
        out_msg.sop       = in_sop[grant_idx];
        out_msg.eop       = in_eop[grant_idx];
        out_msg.data      = in_data[grant_idx];
        out_msg.empty     = in_eop[grant_idx] ? in_empty[grant_idx] : '0;
        in_rdy[grant_idx] = out_rdy;
        if (in_valid[grant_idx]) begin
          // A beat arriving on the limit cycle still wins over the watchdog.
          cnt_nxt = '0;
          if (out_rdy && in_eop[grant_idx]) state_nxt = ARB_IDLE;
        end else if (IDLE_TIMEOUT != 0 && cnt == CNT_LIMIT) begin
          state_nxt = ARB_ABORT;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      ARB_ABORT: begin
        out_msg.valid = 1'b1;
        out_msg.eop   = 1'b1;
        if (out_rdy) begin
          timeout_abort = 1'b1;
          state_nxt     = ARB_IDLE;
        end
      end

      default: state_nxt = ARB_IDLE;
    endcase

    // While reset is held nothing may handshake on either side.
    if (!rst) begin
      out_msg.valid = 1'b0;
      in_rdy        = '0;
      drop_beat     = 1'b0;
      timeout_abort = 1'b0;
    end
  end

  always_comb begin
    grant = '0;
    if (state == ARB_LOCKED) grant[grant_idx] = 1'b1;
  end

  assign busy = (state != ARB_IDLE);

endmodule
